uart_buffered_tx: RTL and testbench
===================================

# uart_buffered_tx

Buffered UART transmitter: accepts bytes from on-chip logic into a FIFO and serializes them as 8N1 frames on the RS232/HC-06 TX line. Bit timing is taken from the shared 16x-oversample `Tick` produced by `UART_BaudRate_generator` (BaudRate 325 gives 9600 baud). It is the transmit-side counterpart to the receive path at top level. Logic can queue a burst of reply bytes without tracking per-byte completion.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of two, minimum 2.
- `ADDR_W`, 4: log2(`DEPTH`).
- `NBITS`, 8: data bits per frame, range 5..8. Only `WrData[NBITS-1:0]` is sent.

Ports:
- `Clk`, input, 1: system clock.
- `Rst_n`, input, 1: asynchronous active-low reset.
- `Tick`, input, 1: one-`Clk`-cycle pulse at 16x the baud rate.
- `WrData`, input, 8: byte to enqueue.
- `WrEn`, input, 1: enqueue strobe. One byte per cycle when high.
- `Full`, output, 1: FIFO holds `DEPTH` entries.
- `Level`, output, `ADDR_W+1`: current FIFO occupancy.
- `Overflow`, output, 1: one-cycle pulse when a write is dropped.
- `Tx`, output, 1: serial line. Idles high.
- `TxBusy`, output, 1: high from the pop until the end of the stop bit.
- `TxDone`, output, 1: one-cycle pulse at the end of each stop bit.

## Operation
- FIFO:
  - Circular buffer with `ADDR_W`-bit read and write pointers plus an `ADDR_W+1`-bit count.
  - Pointers wrap from `DEPTH-1` to 0.
  - `Full` is asserted when count equals `DEPTH`.
  - A write while `Full`=1 is dropped and `Overflow` pulses. This holds even if a pop occurs in the same cycle.
  - A simultaneous write and pop leaves `Level` unchanged.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
  - IDLE: `Tx`=1. If `Level`≠0, pop the head into the shift register, clear the tick and bit counters, and go to START.
  - START: `Tx`=0. After 16 `Tick` pulses, go to DATA.
  - DATA: `Tx` = shift register bit 0 (LSB first). Every 16 ticks, shift right and increment the bit counter. After bit `NBITS-1` completes, go to PARITY (if compiled in) or STOP.
  - STOP: `Tx`=1. On the 16th tick, pulse `TxDone` and go to IDLE.
- Tick counter is 4 bits and counts only on cycles where `Tick`=1. A bit period ends when the counter is 15 and `Tick`=1.
- `Tick` pulses in IDLE are ignored.
- `Tx`, `TxBusy` and `TxDone` are registered outputs.

## Timing
- Reset values: `Tx`=1, `TxBusy`=0, `TxDone`=0, `Full`=0, `Level`=0, `Overflow`=0. FSM returns to IDLE and the pointers to 0.
- Reset is asynchronous. Asserting it mid-frame forces `Tx` high immediately, aborts the frame and discards all FIFO contents.
- Write latency:
  - Write at cycle N with FIFO empty and FSM in IDLE: `Level`=1 at N+1.
  - Pop at N+1; `Level`=0 and `TxBusy`=1 at N+2.
  - `Tx` falls at N+2.
- Frame length is exactly (1+`NBITS`+1)×16 `Tick` pulses, plus up to one tick period of start-bit jitter. The jitter comes from `Tick` phase at the pop.
- Back-to-back frames:
  - `TxDone` pulses at cycle M, and the FSM is in IDLE at M+1.
  - If data is queued, the pop happens at M+1 and the next start bit begins at M+2.
  - `TxBusy` drops for exactly one cycle (M+1).
- `Overflow` asserts the cycle after the dropped write.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: a PARITY state is inserted after DATA. It sends the even parity (XOR of the `NBITS` data bits) for 16 ticks, making the frame 8E1 at `NBITS`=8.
  - Undefined: the PARITY state and its logic are absent, and DATA goes directly to STOP.
  - The HC-06 build leaves it undefined.

## Test plan
- Reset with `Tick` every 4 cycles, then write 0x55 once:
  - `Tx` is low for 16 ticks, then 1,0,1,0,1,0,1,0 at 16 ticks each, then high for 16 ticks.
  - One `TxDone` pulse.
  - `Level` is back at 0 two cycles after the write.
- Write 0xA3, 0x0F, 0xFF on consecutive cycles: three contiguous frames in that order, each with a one-cycle `TxBusy` gap and three `TxDone` pulses.
- Hold `Tick` at 0 and write 17 bytes:
  - The first pop happens immediately, so 16 entries reach `Full`=1.
  - Writing 0x11 on the 18th write cycle gives one `Overflow` pulse and `Level` stays 16.
- Pointer wrap: continuously stream 40 bytes 0x00..0x27 with `Full`-aware writes. All 40 must be received in order by a bench UART decoder.
- Assert `Rst_n`=0 during data bit 3 of 0xC6: `Tx`=1 asynchronously, `Level`=0 and no `TxDone` pulse. After release, no frame is sent.
- With `UART_TX_PARITY_EN` defined, write 0x07: parity bit 1 and frame length 11×16 ticks. With 0x03, parity bit 0.

Source files
------------

// File: rtl/uart_buffered_tx.sv
// Buffered UART transmitter: a DEPTH-entry FIFO feeding a 16x-oversampled 8N1 serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_buffered_tx #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int NBITS  = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Tick,
    input  logic [7:0]        WrData,
    input  logic              WrEn,
    output logic              Full,
    output logic [ADDR_W:0]   Level,
    output logic              Overflow,
    output logic              Tx,
    output logic              TxBusy,
    output logic              TxDone
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [2:0]      LAST_BIT  = 3'(NBITS - 1);

    logic [NBITS-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;

    state_e            state_q, state_d;
    logic [3:0]        tick_cnt_q, tick_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [NBITS-1:0]  shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic              full;
    logic              wr_accept;
    logic              pop;
    logic              bit_end;

    assign full      = (count_q == DEPTH_CNT);
    assign wr_accept = WrEn && !full;
    assign bit_end   = Tick && (tick_cnt_q == 4'd15);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = WrEn && full;
        if (wr_accept) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (pop)       rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves a latch behind.
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        if (state_q != S_IDLE && Tick) tick_cnt_d = tick_cnt_q + 4'd1;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                // Holding off for the TxDone cycle gives TxBusy its one-cycle gap between frames.
                if (count_q != '0 && !done_q) begin
                    pop        = 1'b1;
                    shreg_d    = mem_q[rd_ptr_q];
                    tick_cnt_d = 4'd0;
                    bit_cnt_d  = 3'd0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_d   = ^mem_q[rd_ptr_q];
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d = shreg_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments make every flop sample the pre-edge values of the others.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            tick_cnt_q <= 4'd0;
            bit_cnt_q  <= 3'd0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge Clk) begin
        if (wr_accept) mem_q[wr_ptr_q] <= WrData[NBITS-1:0];
    end

    assign Full     = full;
    assign Level    = count_q;
    assign Overflow = overflow_q;
    assign Tx       = tx_q;
    assign TxBusy   = busy_q;
    assign TxDone   = done_q;

endmodule

// File: tb/tb_uart_buffered_tx.sv
// Bench for uart_buffered_tx: vector table, hand-written corner sequences, and a
// tick-counting line decoder that pops expected frames from a scoreboard queue.
`timescale 1ns/1ps
module tb_uart_buffered_tx;

`ifdef UART_TX_PARITY_EN
    localparam int NSLOTS = 11;
`else
    localparam int NSLOTS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic [4:0] level;
    logic       overflow;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    uart_buffered_tx #(.DEPTH(16), .ADDR_W(4), .NBITS(8)) dut (
        .Clk(clk), .Rst_n(rst_n), .Tick(tick), .WrData(wr_data), .WrEn(wr_en),
        .Full(full), .Level(level), .Overflow(overflow),
        .Tx(tx), .TxBusy(tx_busy), .TxDone(tx_done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    bit          tick_en = 1'b0;
    int          done_cnt = 0;
    int          ovf_cnt = 0;
    int          frames_rx = 0;
    bit          rx_active = 1'b0;
    int          rx_k = 0;
    logic [10:0] exp_q [$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
    } vec_t;
    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line, slot i of the frame in bit i: start, data LSB first, [parity], stop.
    function automatic logic [10:0] model_line(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    function automatic logic [10:0] table_line(input logic [9:0] l10);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^l10[8:1], l10[8:0]};
`else
        return {1'b0, l10};
`endif
    endfunction

    initial begin : tick_gen
        int div;
        div  = 0;
        tick = 1'b0;
        forever begin
            @(posedge clk); #1;
            div  = (div + 1) % 4;
            tick = tick_en && (div == 0);
        end
    end

    initial begin : pulse_mon
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_done === 1'b1) done_cnt++;
            if (rst_n === 1'b1 && overflow === 1'b1) ovf_cnt++;
        end
    end

    initial begin : decoder
        logic [10:0] line;
        logic        first_val;
        bit          stable;
        bit          done_pending;
        int          slot;
        int          ph;
        line = '0; first_val = 1'b1; stable = 1'b1; done_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                rx_active    = 1'b0;
                done_pending = 1'b0;
                continue;
            end
            if (done_pending) begin
                check("txdone_after_last_tick", tx_done, 1);
                done_pending = 1'b0;
            end
            if (!rx_active && tx === 1'b0) begin
                rx_active = 1'b1;
                rx_k      = 0;
                line      = '0;
                stable    = 1'b1;
            end
            if (rx_active && tick === 1'b1) begin
                slot = rx_k / 16;
                ph   = rx_k % 16;
                if (ph == 0) first_val = tx;
                else if (tx !== first_val) stable = 1'b0;
                if (ph == 8) line[slot] = tx;
                if (rx_k == NSLOTS * 16 - 1) begin
                    rx_active = 1'b0;
                    frames_rx++;
                    check("slot_stable", stable, 1);
                    if (exp_q.size() == 0) check("frame_unexpected", 1, 0);
                    else check("frame_line", line, exp_q.pop_front());
                    done_pending = 1'b1;
                end
                rx_k++;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_write(input logic [7:0] d);
        @(posedge clk); #1;
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (tx_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (tx_done !== 1'b1) check("txdone_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin : main
        int d0;
        int f0;
        int n;
        int sent;
        bit high_ok;

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        vecs[0] = '{8'h55, 10'h2AA};
        vecs[1] = '{8'h81, 10'h302};
        vecs[2] = '{8'h00, 10'h200};
        vecs[3] = '{8'hA5, 10'h34A};

        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_full", full, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        #2;
        rst_n   = 1'b1;
        tick_en = 1'b1;
        repeat (8) @(negedge clk);

        // Single writes from idle: latency of Level/TxBusy/Tx, then one full frame each.
        foreach (vecs[i]) begin
            d0 = done_cnt;
            exp_q.push_back(table_line(vecs[i].line));
            drive_write(vecs[i].data);
            @(negedge clk);
            check("level_after_write", level, 1);
            check("busy_before_pop", tx_busy, 0);
            @(negedge clk);
            check("level_after_pop", level, 0);
            check("busy_after_pop", tx_busy, 1);
            check("tx_start_edge", tx, 0);
            wait_done(1000);
            repeat (3) @(negedge clk);
            check("single_done_pulse", done_cnt - d0, 1);
            check("line_idle_high", tx, 1);
        end

        // Back-to-back: three queued bytes, one-cycle TxBusy gap after each TxDone.
        d0 = done_cnt;
        @(posedge clk); #1;
        wr_en = 1'b1; wr_data = 8'hA3; exp_q.push_back(model_line(8'hA3));
        @(posedge clk); #1;
        wr_data = 8'h0F; exp_q.push_back(model_line(8'h0F));
        @(posedge clk); #1;
        wr_data = 8'hFF; exp_q.push_back(model_line(8'hFF));
        @(posedge clk); #1;
        wr_en = 1'b0;
        for (int f = 0; f < 3; f++) begin
            wait_done(1000);
            check("b2b_busy_at_done", tx_busy, 1);
            @(negedge clk);
            check("b2b_busy_gap", tx_busy, 0);
            @(negedge clk);
            check("b2b_busy_after_gap", tx_busy, (f < 2) ? 1 : 0);
            check("b2b_tx_after_gap", tx, (f < 2) ? 0 : 1);
        end
        repeat (2) @(negedge clk);
        check("b2b_done_count", done_cnt - d0, 3);
        check("b2b_sb_empty", exp_q.size(), 0);

        // Fill with Tick held low: first byte pops, 16 more fill, the 18th write overflows.
        tick_en = 1'b0;
        repeat (4) @(negedge clk);
        d0 = ovf_cnt;
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            wr_en   = 1'b1;
            wr_data = (i == 17) ? 8'h11 : 8'(8'h20 + i);
            if (i == 17) begin
                @(negedge clk);
                check("fill_full", full, 1);
                check("fill_level", level, 16);
                check("fill_no_ovf", overflow, 0);
            end
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        check("ovf_pulse", overflow, 1);
        check("ovf_level_held", level, 16);
        @(negedge clk);
        check("ovf_single", overflow, 0);
        check("ovf_count", ovf_cnt - d0, 1);
        pulse_reset();
        tick_en = 1'b1;
        repeat (8) @(negedge clk);

        // Stream 40 bytes with Full-aware writes to wrap both pointers.
        f0 = frames_rx; sent = 0; n = 0;
        while (sent < 40 && n < 25000) begin
            @(posedge clk); #1;
            if (!full) begin
                wr_en   = 1'b1;
                wr_data = 8'(sent);
                exp_q.push_back(model_line(8'(sent)));
                sent++;
            end else begin
                wr_en = 1'b0;
            end
            n++;
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        check("stream_all_written", sent, 40);
        n = 0;
        while (frames_rx - f0 < 40 && n < 15000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("stream_frames", frames_rx - f0, 40);
        check("stream_sb_empty", exp_q.size(), 0);

        // Reset mid data bit 3 of 0xC6: line must go high at once and stay quiet.
        exp_q.push_back(model_line(8'hC6));
        drive_write(8'hC6);
        n = 0;
        while (!(rx_active && rx_k >= 16 * 4 + 8) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_bit3", rx_active, 1);
        check("tx_bit3_low", tx, 0);
        d0 = done_cnt; f0 = frames_rx;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_level", level, 0);
        check("async_rst_busy", tx_busy, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        high_ok = 1'b1;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (tx !== 1'b1) high_ok = 1'b0;
        end
        check("post_rst_tx_high", high_ok, 1);
        check("post_rst_no_done", done_cnt - d0, 0);
        check("post_rst_no_frame", frames_rx - f0, 0);
        check("post_rst_level", level, 0);

`ifdef UART_TX_PARITY_EN
        // Parity build: 0x07 carries parity 1, 0x03 parity 0, both 11x16 ticks long.
        exp_q.push_back(11'h60E);
        drive_write(8'h07);
        wait_done(1200);
        exp_q.push_back(11'h406);
        drive_write(8'h03);
        wait_done(1200);
        repeat (3) @(negedge clk);
        check("parity_sb_empty", exp_q.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
